c1541_sd_arbiter: RTL and testbench

Shares one host SD sector channel (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between NUM_DRIVES per-drive track buffers, each of which issues single-sector read/write requests. Round-robin arbitration. Within one drive, a write takes precedence over a read. An ack watchdog guarantees that a lost host response never deadlocks the channel. Sits between the drive instances and the top-level SD/HPS bridge.

---
 rtl/c1541_sd_arbiter.sv | 169 ++++++++++++++++
 tb/tb_c1541_sd_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one host SD sector channel between drives.
// Writes win over reads within a drive; a watchdog abandons lost acks.
module c1541_sd_arbiter #(
  parameter int NUM_DRIVES = 2,
  parameter int TIMEOUT    = 3200000,
  localparam int GW        = $clog2(NUM_DRIVES)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_DRIVES-1:0]     req_rd,
  input  logic [NUM_DRIVES-1:0]     req_wr,
  input  logic [32*NUM_DRIVES-1:0]  req_lba,
  output logic [NUM_DRIVES-1:0]     drv_ack,
  output logic [NUM_DRIVES-1:0]     drv_done,
  output logic [NUM_DRIVES-1:0]     drv_err,
  output logic [NUM_DRIVES-1:0]     drv_buff_wr,
  input  logic [8*NUM_DRIVES-1:0]   drv_buff_din,
  output logic [31:0]               sd_lba,
  output logic                      sd_rd,
  output logic                      sd_wr,
  input  logic                      sd_ack,
  input  logic                      sd_buff_wr,
  output logic [7:0]                sd_buff_din,
  output logic                      busy,
  output logic [GW-1:0]             grant
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, XFER, GAP
  } state_e;

  localparam logic [23:0] TMAX = 24'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_DRIVES - 1);

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [31:0]           lba_q, lba_d;
  logic                  opwr_q, opwr_d;
  logic [23:0]           cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  ack_q;
  logic [NUM_DRIVES-1:0] done_q, done_d;
  logic [NUM_DRIVES-1:0] err_q, err_d;

  logic [NUM_DRIVES-1:0] pend;
  logic [GW-1:0]         pick;
  logic                  found;
  int                    idx;

  assign pend = req_rd | req_wr;

  // First pending drive after the previous owner, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_DRIVES; i++) begin
      idx = (int'(last_q) + i) % NUM_DRIVES;
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      lba_q   <= '0;
      opwr_q  <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      opwr_q  <= opwr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= sd_ack;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    opwr_d  = opwr_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          lba_d   = req_lba[32*int'(pick) +: 32];
          opwr_d  = req_wr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_d    = !opwr_q;
        wr_d    = opwr_q;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (cnt_q == TMAX) begin
          rd_d           = 1'b0;
          wr_d           = 1'b0;
          err_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      XFER: begin
        if (ack_q && !sd_ack) begin
          done_d[grant_q] = 1'b1;
          last_d          = grant_q;
          state_d         = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data path routing is combinational and only live during XFER.
  always_comb begin
    drv_ack     = '0;
    drv_buff_wr = '0;
    sd_buff_din = 8'h00;
    if (state_q == XFER) begin
      drv_ack[grant_q]     = sd_ack;
      drv_buff_wr[grant_q] = sd_buff_wr;
      sd_buff_din          = drv_buff_din[8*int'(grant_q) +: 8];
    end
  end

  assign sd_lba   = lba_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign drv_done = done_q;
  assign drv_err  = err_q;
  assign busy     = (state_q != IDLE);
  assign grant    = grant_q;

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Bench for c1541_sd_arbiter: acts as host and requesters, predicts
// grant order, opcode, LBA and data routing from the arbitration rules.
module tb_c1541_sd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_rd, req_wr;
  logic [63:0] req_lba;
  logic [1:0]  drv_ack, drv_done, drv_err, drv_buff_wr;
  logic [15:0] drv_buff_din;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        busy;
  logic [0:0]  grant;

  int vecs = 0;
  int errs = 0;
  int model_last;
  int obs_q[$];

  c1541_sd_arbiter #(.NUM_DRIVES(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .drv_ack(drv_ack), .drv_done(drv_done), .drv_err(drv_err),
    .drv_buff_wr(drv_buff_wr), .drv_buff_din(drv_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(logic [1:0] p, int last);
    for (int k = 1; k <= 2; k++)
      if (p[(last + k) % 2]) return (last + k) % 2;
    return -1;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; drv_buff_din = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    model_last = 1;
    tick();
  endtask

  task automatic do_xfer(input int nbytes, input bit tamper);
    int d, n;
    logic ewr;
    logic [31:0] elba;
    logic [1:0] oh;
    logic [7:0] eb;
    d = rr_pick(req_rd | req_wr, model_last);
    vecs++;
    if (d < 0) begin
      errs++;
      $display("FAIL xfer_setup: no pending drive");
      return;
    end
    ewr = req_wr[d];
    elba = req_lba[32*d +: 32];
    oh = 2'(1 << d);
    n = 0;
    while (!(sd_rd || sd_wr) && n < 10) begin
      tick();
      n++;
    end
    vecs++;
    if (!(sd_rd || sd_wr)) begin
      errs++;
      $display("FAIL strobe_wait: no strobe within 10 cycles");
      return;
    end
    obs_q.push_back(int'(grant));
    vecs++;
    if ({sd_wr, sd_rd, sd_lba, grant, busy} !== {ewr, ~ewr, elba, 1'(d), 1'b1}) begin
      errs++;
      $display("FAIL issue: wr/rd/lba/grant=%b/%b/%h/%0d want %b/%b/%h/%0d",
               sd_wr, sd_rd, sd_lba, grant, ewr, ~ewr, elba, d);
    end
    if (tamper) begin
      req_lba[32*d +: 32] = ~elba;
      req_rd[d] = ~req_rd[d];
      tick();
      vecs++;
      if ({sd_wr, sd_rd, sd_lba} !== {ewr, ~ewr, elba}) begin
        errs++;
        $display("FAIL latched: wr/rd/lba=%b/%b/%h want %b/%b/%h",
                 sd_wr, sd_rd, sd_lba, ewr, ~ewr, elba);
      end
    end
    repeat ($urandom_range(0, 3)) tick();
    sd_ack = 1'b1;
    tick();
    vecs++;
    if ({sd_wr, sd_rd, busy} !== 3'b001) begin
      errs++;
      $display("FAIL ack_drop: wr/rd/busy=%b/%b/%b want 0/0/1", sd_wr, sd_rd, busy);
    end
    for (int i = 0; i < nbytes; i++) begin
      sd_buff_wr = 1'($urandom_range(0, 1));
      drv_buff_din = 16'($urandom);
      #1;
      eb = drv_buff_din[8*d +: 8];
      vecs++;
      if ({drv_ack, drv_buff_wr, sd_buff_din} !== {oh, sd_buff_wr ? oh : 2'b00, eb}) begin
        errs++;
        $display("FAIL route: ack/bwr/din=%b/%b/%h want %b/%b/%h", drv_ack,
                 drv_buff_wr, sd_buff_din, oh, sd_buff_wr ? oh : 2'b00, eb);
      end
      tick();
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    vecs++;
    if ({drv_done, drv_ack, drv_err} !== {oh, 4'b0000}) begin
      errs++;
      $display("FAIL done: done/ack/err=%b/%b/%b want %b/00/00",
               drv_done, drv_ack, drv_err, oh);
    end
    req_rd[d] = 1'b0;
    req_wr[d] = 1'b0;
    model_last = d;
    tick();
    vecs++;
    if ({drv_done, busy} !== 3'b000) begin
      errs++;
      $display("FAIL gap_end: done/busy=%b/%b want 00/0", drv_done, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; drv_buff_din = '0;
    #1;
    vecs++;
    if ({busy, sd_rd, sd_wr, sd_lba, grant, drv_ack, drv_done, drv_err} !== '0) begin
      errs++;
      $display("FAIL reset: busy/rd/wr/lba/grant=%b/%b/%b/%h/%0d want all 0",
               busy, sd_rd, sd_wr, sd_lba, grant);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    model_last = 1;
    tick();
  endtask

  task automatic test_spurious();
    sd_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd_buff_wr = 1'b1;
      drv_buff_din = 16'($urandom);
      #1;
      vecs++;
      if ({drv_ack, drv_buff_wr, sd_buff_din, busy} !== 13'd0) begin
        errs++;
        $display("FAIL spurious: ack/bwr/din/busy=%b/%b/%h/%b want 0",
                 drv_ack, drv_buff_wr, sd_buff_din, busy);
      end
      tick();
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    req_rd[0] = 1'b1;
    req_lba[31:0] = 32'h123;
    tick();
    vecs++;
    if ({sd_rd, busy} !== 2'b01) begin
      errs++;
      $display("FAIL latency1: rd/busy=%b/%b want 0/1", sd_rd, busy);
    end
    tick();
    vecs++;
    if ({sd_rd, sd_lba} !== {1'b1, 32'h123}) begin
      errs++;
      $display("FAIL latency2: rd/lba=%b/%h want 1/00000123", sd_rd, sd_lba);
    end
    do_xfer(512, 1'b0);
  endtask

  task automatic test_priority();
    req_rd[1] = 1'b1;
    req_wr[1] = 1'b1;
    req_lba[63:32] = 32'd7;
    do_xfer(8, 1'b1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    obs_q.delete();
    for (int r = 0; r < 2; r++) begin
      req_rd = 2'b11;
      req_lba = {32'($urandom), 32'($urandom)};
      do_xfer(4, 1'b0);
      do_xfer(4, 1'b0);
    end
    vecs++;
    if (obs_q.size() != 4 || obs_q[0] != 0 || obs_q[1] != 1 ||
        obs_q[2] != 0 || obs_q[3] != 1) begin
      errs++;
      $display("FAIL rr_order: got %p want 0,1,0,1", obs_q);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    req_wr[0] = 1'b1;
    req_rd[1] = 1'b1;
    req_lba = {32'($urandom), 32'($urandom)};
    repeat (2) tick();
    n = 0;
    while (sd_wr && n < 40) begin
      n++;
      tick();
    end
    vecs++;
    if (n != 16 || drv_err !== 2'b01 || drv_done !== 2'b00 || sd_wr !== 1'b0) begin
      errs++;
      $display("FAIL timeout: cycles/err/done=%0d/%b/%b want 16/01/00",
               n, drv_err, drv_done);
    end
    req_wr[0] = 1'b0;
    model_last = 0;
    tick();
    vecs++;
    if ({drv_err, grant, busy} !== 4'b0011) begin
      errs++;
      $display("FAIL post_timeout: err/grant/busy=%b/%0d/%b want 00/1/1",
               drv_err, grant, busy);
    end
    do_xfer(3, 1'b0);
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    req_rd[0] = 1'b1;
    req_lba[31:0] = 32'($urandom);
    n = 0;
    while (!sd_rd && n < 10) begin
      tick();
      n++;
    end
    sd_ack = 1'b1;
    tick();
    sd_buff_wr = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({sd_rd, sd_wr, drv_ack, drv_buff_wr, busy, drv_done, drv_err} !== 10'd0) begin
      errs++;
      $display("FAIL reset_xfer: rd/ack/bwr/busy/done=%b/%b/%b/%b/%b want 0",
               sd_rd, drv_ack, drv_buff_wr, busy, drv_done);
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    reset_n = 1'b1;
    model_last = 1;
    tick();
    vecs++;
    if (drv_done !== 2'b00) begin
      errs++;
      $display("FAIL reset_nodone: done=%b want 00", drv_done);
    end
    req_rd[1] = 1'b1;
    req_lba[63:32] = 32'($urandom);
    obs_q.delete();
    do_xfer(2, 1'b0);
    do_xfer(2, 1'b0);
    vecs++;
    if (obs_q.size() != 2 || obs_q[0] != 0 || obs_q[1] != 1) begin
      errs++;
      $display("FAIL reset_order: got %p want 0,1", obs_q);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      for (int d = 0; d < 2; d++) begin
        if (!(req_rd[d] || req_wr[d]) && $urandom_range(0, 1) == 1) begin
          req_rd[d] = 1'($urandom_range(0, 1));
          req_wr[d] = 1'($urandom_range(0, 1));
          req_lba[32*d +: 32] = 32'($urandom);
        end
      end
      if ((req_rd | req_wr) == 2'b00) begin
        req_wr[it % 2] = 1'($urandom_range(0, 1));
        req_rd[it % 2] = ~req_wr[it % 2];
        req_lba[32*(it % 2) +: 32] = 32'($urandom);
      end
      do_xfer($urandom_range(1, 8), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_single_read();
    test_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid_xfer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
